i2s_frame_packer: RTL and testbench

Packetizes one I2S capture channel's byte stream into framed, backpressured AXI-Stream packets for the inter-FPGA transport. Sits directly downstream of the per-channel I2S capture PHY (8-bit `tvalid`/`tdata`/`tlast`, no `tready`). Store-and-forward: a frame is emitted only once it is complete. Frames that overflow the buffer, exceed the length limit or are cut by disable are dropped whole.

---
 rtl/i2s_frame_packer_pkg.sv | 21 ++
 rtl/pkt_byte_ram.sv | 31 +++
 rtl/i2s_frame_packer.sv | 206 ++++++++++++++++++++
 tb/tb_i2s_frame_packer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_frame_packer_pkg.sv
`default_nettype none
// ==== i2s_frame_packer_pkg : shared packet header constants and output FSM encoding ====
// ==== rev 1.0 ====
package i2s_frame_packer_pkg;

    localparam logic [3:0] HDR_MAGIC  = 4'hA;
    localparam int         HDR_LEN    = 4;
    localparam int         DROP_CNT_W = 16;
    localparam int         SEQ_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_HDR2 = 3'd3,
        ST_HDR3 = 3'd4,
        ST_PAY  = 3'd5
    } out_state_t;

endpackage
`default_nettype wire

// File: rtl/pkt_byte_ram.sv
`default_nettype none
// ==== pkt_byte_ram : simple dual-port payload RAM, sync write, registered read with enable ====
// ==== rev 1.0 ====
module pkt_byte_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 9,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read register only updates on rd_en, so it doubles as the hold register under backpressure.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_frame_packer.sv
`default_nettype none
// ==== i2s_frame_packer : store-and-forward I2S byte-stream to AXI-Stream packetizer ====
// ==== rev 1.0 ====
module i2s_frame_packer
    import i2s_frame_packer_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int MAX_LEN = 192,
    parameter int CH_ID   = 0
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  s_axis_tvalid,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  i_enable,
    input  logic [3:0]            i_dst_fpga_index,
    output logic [SEQ_W-1:0]      o_seq,
    output logic [DROP_CNT_W-1:0] o_drop_count
);

    localparam int               AW        = $clog2(DEPTH);
    localparam int               LEN_W     = AW + 1;
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [7:0]       CH_ID_C   = 8'(CH_ID);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         commit_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         frames_avail;
    logic [LEN_W-1:0]      cur_len;
    logic                  discard;
    logic [DROP_CNT_W-1:0] drop_count;
    logic [SEQ_W-1:0]      seq;
    logic [3:0]            dst_idx;

    out_state_t            state;
    out_state_t            state_nxt;

    logic                  ram_full;
    logic                  over_len;
    logic                  accept;
    logic                  drop;
    logic                  commit;
    logic                  out_hs;
    logic                  pkt_done;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [8:0]            rd_data;

    pkt_byte_ram #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // ------------------------------------------------------------------ input side
    // rd_ptr only advances on a payload handshake, so a slot stays owned until consumed.
    assign ram_full = (wr_ptr + AW'(1)) == rd_ptr;
    assign over_len = (cur_len + LEN_W'(1)) > MAX_LEN_C;

    always_comb begin
        accept = 1'b0;
        drop   = 1'b0;
        if (!i_enable) begin
            drop = (cur_len != '0);
        end else if (s_axis_tvalid && !discard) begin
            if (ram_full || over_len) begin
                drop = 1'b1;
            end else begin
                accept = 1'b1;
            end
        end
    end

    assign commit = accept && s_axis_tlast;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            cur_len    <= '0;
            discard    <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            wr_ptr  <= commit_ptr;
            cur_len <= '0;
            if (drop_count != '1) begin
                drop_count <= drop_count + DROP_CNT_W'(1);
            end
            // A drop on the frame's own tlast beat ends the frame, nothing left to swallow.
            discard <= i_enable ? !s_axis_tlast : 1'b1;
        end else if (accept) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (s_axis_tlast) begin
                commit_ptr <= wr_ptr + AW'(1);
                cur_len    <= '0;
            end else begin
                cur_len <= cur_len + LEN_W'(1);
            end
        end else if (i_enable && s_axis_tvalid && discard && s_axis_tlast) begin
            discard <= 1'b0;
        end
    end

    // ------------------------------------------------------------------ output side
    assign out_hs   = m_axis_tvalid && m_axis_tready;
    assign pkt_done = out_hs && (state == ST_PAY) && rd_data[8];

    // Read one ahead: HDR3 fetches the first byte, each PAY handshake fetches the next.
    assign rd_en   = (state == ST_HDR3) || ((state == ST_PAY) && out_hs);
    assign rd_addr = (state == ST_PAY) ? (rd_ptr + AW'(1)) : rd_ptr;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            frames_avail <= '0;
            seq          <= '0;
            rd_ptr       <= '0;
            dst_idx      <= '0;
        end else begin
            case ({commit, pkt_done})
                2'b10:   frames_avail <= frames_avail + AW'(1);
                2'b01:   frames_avail <= frames_avail - AW'(1);
                default: frames_avail <= frames_avail;
            endcase
            if (pkt_done) begin
                seq <= seq + SEQ_W'(1);
            end
            if ((state == ST_PAY) && out_hs) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if ((state == ST_IDLE) && (frames_avail != '0)) begin
                dst_idx <= i_dst_fpga_index;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (frames_avail != '0) state_nxt = ST_HDR0;
            ST_HDR0: if (out_hs) state_nxt = ST_HDR1;
            ST_HDR1: if (out_hs) state_nxt = ST_HDR2;
            ST_HDR2: if (out_hs) state_nxt = ST_HDR3;
            ST_HDR3: if (out_hs) state_nxt = ST_PAY;
            ST_PAY:  if (pkt_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        case (state)
            ST_HDR0: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {HDR_MAGIC, dst_idx};
            end
            ST_HDR1: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = CH_ID_C;
            end
            ST_HDR2: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = seq[15:8];
            end
            ST_HDR3: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = seq[7:0];
            end
            ST_PAY: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = rd_data[7:0];
                m_axis_tlast  = rd_data[8];
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

    assign o_seq        = seq;
    assign o_drop_count = drop_count;

endmodule
`default_nettype wire

// File: tb/tb_i2s_frame_packer.sv
`default_nettype none
// ==== tb_i2s_frame_packer : directed scoreboard bench for i2s_frame_packer (DEPTH=16, MAX_LEN=12, CH_ID=5) ====
// ==== rev 1.0 ====
module tb_i2s_frame_packer;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tlast = 1'b0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tlast;
    logic        i_enable = 1'b1;
    logic [3:0]  i_dst_fpga_index = 4'h0;
    logic [15:0] o_seq;
    logic [15:0] o_drop_count;

    int          compared = 0;
    int          mismatched = 0;
    int          beats = 0;
    int          ready_mode = 0;
    logic [8:0]  exp_q[$];
    logic [15:0] exp_seq = 16'h0000;
    logic [15:0] exp_drop = 16'h0000;
    logic        stall_q = 1'b0;
    logic [8:0]  stall_bits = 9'h000;

    i2s_frame_packer #(
        .DEPTH   (16),
        .MAX_LEN (12),
        .CH_ID   (5)
    ) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tlast     (s_axis_tlast),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast),
        .i_enable         (i_enable),
        .i_dst_fpga_index (i_dst_fpga_index),
        .o_seq            (o_seq),
        .o_drop_count     (o_drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

    // mode 0: ready low, 1: ready high, 2: toggle every cycle
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = ~m_axis_tready;
        endcase
    end

    always @(negedge clk) begin
        if (!arst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                compared++;
                assert ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} === {1'b1, stall_bits})
                else begin
                    mismatched++;
                    $error("FAIL stall_hold observed=%h expected=%h",
                           {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, stall_bits});
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $error("FAIL unexpected_beat observed=%h expected=none", {m_axis_tlast, m_axis_tdata});
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    compared++;
                    assert ({m_axis_tlast, m_axis_tdata} === e)
                    else begin
                        mismatched++;
                        $error("FAIL beat observed=%h expected=%h", {m_axis_tlast, m_axis_tdata}, e);
                    end
                end
            end
            stall_q    = m_axis_tvalid && !m_axis_tready;
            stall_bits = {m_axis_tlast, m_axis_tdata};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int len, input int start, input int step);
        exp_q.push_back({1'b0, 4'hA, i_dst_fpga_index});
        exp_q.push_back({1'b0, 8'h05});
        exp_q.push_back({1'b0, exp_seq[15:8]});
        exp_q.push_back({1'b0, exp_seq[7:0]});
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), 8'(start + i * step)});
        end
        exp_seq = exp_seq + 16'd1;
    endtask

    // Called at posedge+#1; returns at posedge+#1 just after the last byte was sampled.
    task automatic send_frame(input int len, input int start, input int step,
                              input bit has_last, input bit expect_out);
        if (expect_out) push_pkt(len, start, step);
        for (int i = 0; i < len; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 8'(start + i * step);
            s_axis_tlast  = has_last && (i == len - 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_in();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        compared++;
        assert (exp_q.size() == 0 && !m_axis_tvalid)
        else begin
            mismatched++;
            $error("FAIL %s drain remaining=%0d expected=0", tag, exp_q.size());
        end
    endtask

    initial begin
        int target;
        int n;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata",  32'(m_axis_tdata),  32'd0);
        check("rst_tlast",  32'(m_axis_tlast),  32'd0);
        check("rst_seq",    32'(o_seq),         32'd0);
        check("rst_drop",   32'(o_drop_count),  32'd0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // single 3-byte frame, latency to first header byte
        i_dst_fpga_index = 4'd3;
        ready_mode       = 1;
        m_axis_tready    = 1'b1;
        send_frame(3, 8'h11, 8'h11, 1'b1, 1'b1);
        idle_in();
        check("lat_n1_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_n2_hdr0", 32'({m_axis_tvalid, m_axis_tdata}), 32'h1A3);
        drain("t1");
        check("t1_seq", 32'(o_seq), 32'(exp_seq));

        // two back-to-back frames under toggling ready
        i_dst_fpga_index = 4'hC;
        ready_mode       = 2;
        send_frame(4, 8'h40, 1, 1'b1, 1'b1);
        send_frame(4, 8'h50, 1, 1'b1, 1'b1);
        idle_in();
        drain("t2");
        check("t2_seq", 32'(o_seq), 32'd3);

        // overflow: pending frame blocks the buffer, next frame overflows
        ready_mode       = 0;
        m_axis_tready    = 1'b0;
        i_dst_fpga_index = 4'd3;
        send_frame(5, 8'h60, 1, 1'b1, 1'b1);
        send_frame(20, 8'h80, 1, 1'b1, 1'b0);
        exp_drop = exp_drop + 16'd1;
        send_frame(3, 8'hA0, 1, 1'b1, 1'b1);
        idle_in();
        @(posedge clk);
        #1;
        check("ovf_drop", 32'(o_drop_count), 32'(exp_drop));
        ready_mode = 1;
        drain("t3");
        check("t3_seq", 32'(o_seq), 32'(exp_seq));

        // length limit: MAX_LEN+1 dropped, exactly MAX_LEN emitted
        send_frame(13, 8'h20, 1, 1'b1, 1'b0);
        exp_drop = exp_drop + 16'd1;
        send_frame(12, 8'h30, 1, 1'b1, 1'b1);
        idle_in();
        check("len_drop", 32'(o_drop_count), 32'(exp_drop));
        drain("t4");
        check("t4_seq", 32'(o_seq), 32'(exp_seq));

        // disable mid-frame while a committed frame is waiting
        ready_mode    = 0;
        m_axis_tready = 1'b0;
        send_frame(3, 8'hC0, 1, 1'b1, 1'b1);
        send_frame(2, 8'hD0, 1, 1'b0, 1'b0);
        i_enable = 1'b0;
        send_frame(3, 8'hD2, 1, 1'b0, 1'b0);
        i_enable = 1'b1;
        exp_drop = exp_drop + 16'd1;
        send_frame(2, 8'hD5, 1, 1'b1, 1'b0);
        send_frame(2, 8'hE0, 1, 1'b1, 1'b1);
        idle_in();
        check("en_drop", 32'(o_drop_count), 32'(exp_drop));
        ready_mode = 1;
        drain("t5");
        check("t5_seq", 32'(o_seq), 32'(exp_seq));
        check("t5_drop", 32'(o_drop_count), 32'(exp_drop));

        // asynchronous reset in the middle of a payload
        send_frame(8, 8'h01, 1, 1'b1, 1'b1);
        idle_in();
        target = beats + 6;
        n = 0;
        while (beats < target && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_pay_reached", 32'(beats >= target), 32'd1);
        arst_n = 1'b0;
        #1;
        check("arst_outputs", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'd0);
        check("arst_seq",  32'(o_seq),        32'd0);
        check("arst_drop", 32'(o_drop_count), 32'd0);
        exp_q.delete();
        exp_seq  = 16'h0000;
        exp_drop = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(3, 8'h70, 1, 1'b1, 1'b1);
        idle_in();
        drain("t6");
        check("t6_seq",  32'(o_seq),        32'd1);
        check("t6_drop", 32'(o_drop_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
